// File: rtl/data_ram_pkg.sv
// Shared definitions for the data RAM responder slice.
//   - default address/data widths used by the responder and the storage array
//   - width of the wait-state counter and of the optional statistics counters
//   - FSM state encoding (exposed on the responder's fsm_state debug port)
//   - sat_inc: saturating increment for the statistics counters
package data_ram_pkg;

  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_DATA_W = 16;
  localparam int STATS_W        = 16;
  // Wait states range 0..15.
  localparam int WAIT_W         = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/data_ram_responder_if.sv
// Request/response bus between a core and the data RAM responder.
// Handshake rules, identical on both channels: a transfer happens on a rising
// clk edge where valid && ready are both 1. The request payload (req_write,
// req_addr, req_wdata) is only looked at on that edge. Once resp_valid is 1 it
// stays 1 and resp_rdata stays stable until the edge where resp_ready is 1.
//   master : core side   (drives req_valid/req_write/req_addr/req_wdata/resp_ready)
//   slave  : responder   (drives req_ready/resp_valid/resp_rdata)
interface data_ram_responder_if #(
  parameter int ADDR_W = data_ram_pkg::DEFAULT_ADDR_W,
  parameter int DATA_W = data_ram_pkg::DEFAULT_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/data_ram_array.sv
// Single-port storage for the responder: synchronous write, registered read.
// On an enabled write the output register takes the write data, so the
// responder can echo the written word without a second access.
// Contents are never reset; only the output register is.
// Ports:
//   clk, rst_n : clock, asynchronous active-high reset (output register only)
//   en         : perform an access this edge
//   we         : 1 = write wdata to addr, 0 = read addr
//   addr/wdata : access address and write data
//   rdata      : registered read (or echoed write) data
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder: accepts one read/write request at a time, waits
// WAIT_CYCLES edges, then presents a response held until the core takes it.
// Parameters: WAIT_CYCLES (0..15), ADDR_W, DATA_W.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active-high (asserted = 1)
//   bus       : request/response bus (slave modport)
//   fsm_state : current FSM state, for observation
//   rd_count, wr_count : completed-transaction counters, saturating at 0xFFFF
//                        (present only when DATA_RAM_STATS_EN is defined)
// Optional feature macro: DATA_RAM_STATS_EN.
module data_ram_responder
  import data_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int DATA_W      = DEFAULT_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_ram_responder_if.slave  bus,
`ifdef DATA_RAM_STATS_EN
  output logic [STATS_W-1:0]   rd_count,
  output logic [STATS_W-1:0]   wr_count,
`endif
  output state_t               fsm_state
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam logic              ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              resp_valid_q;

  logic              accept;
  logic              enter_resp;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Ready goes low with reset itself and comes back in the first cycle after
  // reset is released, without waiting for a clock edge.
  assign bus.req_ready = (state_q == S_IDLE) && !rst_n;
  assign accept        = bus.req_valid && bus.req_ready;

  // The storage access happens on the edge that enters RESP. With zero wait
  // states that is the accept edge itself, so the live request fields are used;
  // otherwise the fields latched at accept are used.
  assign enter_resp = (state_q == S_IDLE && accept && ZERO_WAIT) ||
                      (state_q == S_WAIT && cnt_q == WAIT_W'(1));
  assign ram_we     = (state_q == S_IDLE) ? bus.req_write : write_q;
  assign ram_addr   = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
  assign ram_wdata  = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;

  data_ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (enter_resp),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (ZERO_WAIT) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == WAIT_W'(1)) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - WAIT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = ram_rdata;
  assign fsm_state      = state_q;

`ifdef DATA_RAM_STATS_EN
  logic [STATS_W-1:0] rd_count_q;
  logic [STATS_W-1:0] wr_count_q;

  // A transaction counts as completed on the edge that leaves RESP.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (state_q == S_RESP && bus.resp_ready) begin
      if (write_q) begin
        wr_count_q <= sat_inc(wr_count_q);
      end else begin
        rd_count_q <= sat_inc(rd_count_q);
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule
